// File: rtl/key_debounce_step.sv
// key_debounce_step: conditions a raw, bouncing push-button into clean
// single-cycle pulses for the 7-segment digit counters. The input passes
// through a two-flop synchroniser and is normalised so that 1 = pressed.
// A four-state FSM then debounces it and, if enabled, produces auto-repeat
// step pulses while the button is held.
module key_debounce_step #(
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REP_W           = 26,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step
);

  // Raw level of an unpressed button. The synchroniser resets to this value,
  // so a button held through reset is seen as a fresh press afterwards.
  localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  state_t           state;
  logic             sync_a;
  logic             sync_b;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  logic [REP_W-1:0] rcnt;
  logic             phase;

  // Two-flop synchroniser bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= RAW_IDLE;
      sync_b <= RAW_IDLE;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  assign btn_s = (ACTIVE_LOW != 0) ? ~sync_b : sync_b;

  // Debounce / auto-repeat FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rcnt          <= '0;
      phase         <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step          <= 1'b0;
      case (state)
        IDLE: begin
          level <= 1'b0;
          rcnt  <= '0;
          phase <= 1'b0;
          cnt   <= '0;
          if (btn_s) begin
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            rcnt        <= '0;
            phase       <= 1'b0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
            step        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            // A release wins over a repeat that would fire in the same cycle.
            state <= REL_WAIT;
            cnt   <= '0;
            rcnt  <= '0;
          end else if (REPEAT_EN != 0) begin
            if (!phase && (rcnt == DELAY_LAST)) begin
              step  <= 1'b1;
              phase <= 1'b1;
              rcnt  <= '0;
            end else if (phase && (rcnt == PERIOD_LAST)) begin
              step <= 1'b1;
              rcnt <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end else begin
            rcnt <= '0;
          end
        end
        REL_WAIT: begin
          if (btn_s) begin
            // Bounce back to held: repeat timing restarts from the first delay.
            state <= HELD;
            cnt   <= '0;
            rcnt  <= '0;
            phase <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          rcnt  <= '0;
          phase <= 1'b0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_step.sv
// Bench for key_debounce_step. Two instances share the button and reset:
// dutPlain has auto-repeat off, dutRep has it on. Each directed step drives
// one clock edge and pushes the outputs expected after that edge, derived
// from the documented latencies. A monitor pops and compares them on the
// following falling edge.
module tb_key_debounce_step;

  logic clk;
  logic rst;
  logic btn_in;

  logic levelA, pressA, releaseA, stepA;
  logic levelB, pressB, releaseB, stepB;

  int vectorCount;
  int missCount;

  typedef struct {
    string      tag;
    logic [3:0] expA;
    bit         chkB;
    logic [3:0] expB;
  } expect_t;

  expect_t sbQueue[$];
  string   curTag;

  key_debounce_step #(
    .ACTIVE_LOW(1), .CNT_W(20), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REP_W(26), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dutPlain (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .level(levelA), .press_pulse(pressA), .release_pulse(releaseA), .step(stepA)
  );

  key_debounce_step #(
    .ACTIVE_LOW(1), .CNT_W(20), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REP_W(26), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dutRep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .level(levelB), .press_pulse(pressB), .release_pulse(releaseB), .step(stepB)
  );

  // Free-running 100 MHz style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {level, press, release, step} k edges after the first pressed
  // sample: the press is accepted at edge 6 (DEBOUNCE_CYCLES + 2).
  function automatic logic [3:0] pressExp(input int k);
    if (k < 6) return 4'b0000;
    if (k == 6) return 4'b1101;
    return 4'b1000;
  endfunction

  // Same for k edges after the first released sample while held.
  function automatic logic [3:0] releaseExp(input int k);
    if (k < 6) return 4'b1000;
    if (k == 6) return 4'b0010;
    return 4'b0000;
  endfunction

  // Drive one edge worth of inputs and record what both DUTs should show after it.
  task automatic applyStimulus(input logic b, input logic r, input logic [3:0] ea,
                               input bit cb, input logic [3:0] eb);
    expect_t e;
    btn_in = b;
    rst    = r;
    @(posedge clk);
    e.tag  = curTag;
    e.expA = ea;
    e.chkB = cb;
    e.expB = eb;
    sbQueue.push_back(e);
    #1;
  endtask

  // Compare one scoreboard entry against the live outputs.
  task automatic checkOutput(input expect_t e);
    logic [3:0] obsA;
    logic [3:0] obsB;
    obsA = {levelA, pressA, releaseA, stepA};
    obsB = {levelB, pressB, releaseB, stepB};
    vectorCount++;
    assert (obsA === e.expA) else begin
      missCount++;
      $error("[TB] FAIL %s plain: observed %b expected %b", e.tag, obsA, e.expA);
    end
    if (e.chkB) begin
      vectorCount++;
      assert (obsB === e.expB) else begin
        missCount++;
        $error("[TB] FAIL %s repeat: observed %b expected %b", e.tag, obsB, e.expB);
      end
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sbQueue.size() != 0) begin
      checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    vectorCount = 0;
    missCount   = 0;
    btn_in      = 1'b1;
    rst         = 1'b1;

    // Reset with button released, then idle.
    curTag = "reset";
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000);
    curTag = "idle";
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);

    // Bounce: 3 pressed / 1 released, never long enough to be accepted.
    curTag = "bounce";
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000);
      applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);

    // Clean press, first pressed sample is k = 0.
    curTag = "press";
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, pressExp(k), 1'b0, 4'b0000);

    // Two-cycle release glitch while held: no release, level stays 1.
    curTag = "glitch";
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000);

    // Steady release, first released sample is k = 0.
    curTag = "release";
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, releaseExp(k), 1'b0, 4'b0000);

    // Auto-repeat: press accepted at k = 6, repeats at +10 then every 3.
    curTag = "repRst";
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000);
    curTag = "repeat";
    for (int k = 0; k <= 36; k++) begin
      logic [3:0] eb;
      eb    = pressExp(k);
      eb[0] = (k == 6) || ((k >= 16) && (((k - 16) % 3) == 0));
      applyStimulus(1'b0, 1'b0, pressExp(k), 1'b1, eb);
    end

    // Return to idle, then reset in the middle of the press debounce.
    curTag = "midRst";
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000);

    // Held button through reset: full debounce again after reset releases.
    curTag = "heldRst";
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, pressExp(k), 1'b0, 4'b0000);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000);
    curTag = "afterRst";
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, pressExp(k), 1'b0, 4'b0000);

    // Let the monitor drain the last entries; a leftover entry is a failure.
    repeat (3) @(negedge clk);
    if (sbQueue.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: observed %0d pending entries, expected 0", sbQueue.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/key_debounce_step.md
Name: key_debounce_step

Overview:
- Upstream conditioning stage for the 7-segment digit counters on the MAX 10 board.
- Takes a raw, bouncing, asynchronous push-button input, synchronises it to the system clock and debounces it with an FSM.
- Emits clean single-cycle pulses (press, release, step with optional auto-repeat) that drive a counter's increment input.

Parameters:
- ACTIVE_LOW, 1, 1 = button reads 0 when pressed (board KEYs); 0 = active-high input.
- CNT_W, 20, width of the debounce counter.
- DEBOUNCE_CYCLES, 500000, input must hold stable this many clocks to be accepted (10 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
- REPEAT_EN, 0, 1 = generate auto-repeat step pulses while held.
- REP_W, 26, width of the repeat counter.
- REPEAT_DELAY, 25000000, clocks from press pulse to first repeat; must be >=1 and fit REP_W.
- REPEAT_PERIOD, 10000000, clocks between subsequent repeats; must be >=1 and fit REP_W.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  raw button, asynchronous to clk.
- level  output  1  debounced state, 1 = pressed.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on accepted release.
- step  output  1  press_pulse OR auto-repeat pulse, one cycle each.

Behaviour:
- Synchroniser: two flops sample btn_in; output is polarity-normalised to btn_s (1 = pressed). Both flops reset to the inactive level.
- Reset (rst high at an edge): FSM goes to IDLE; both counters and the repeat-phase flag clear; all outputs are 0 from that edge. Reset takes priority over every other event, including mid-debounce and while held.
- All outputs are registered. level is 1 in HELD and REL_WAIT, 0 otherwise.
- IDLE: if btn_s = 1, go to PRESS_WAIT with cnt = 0.
- PRESS_WAIT:
  - If btn_s = 0, return to IDLE. No pulse.
  - Else if cnt == DEBOUNCE_CYCLES-1, go to HELD and assert press_pulse and step for one cycle; rcnt = 0, phase = 0.
  - Else cnt increments.
- HELD:
  - If btn_s = 0, go to REL_WAIT with cnt = 0. Release takes priority over a coincident repeat, so no repeat pulse that cycle.
  - Else if REPEAT_EN = 1:
    - phase = 0: when rcnt == REPEAT_DELAY-1, pulse step, set phase = 1, rcnt = 0.
    - phase = 1: when rcnt == REPEAT_PERIOD-1, pulse step, rcnt = 0.
    - Otherwise rcnt increments.
  - Repeat pulses do not assert press_pulse.
  - REPEAT_EN = 0: rcnt is held at 0.
- REL_WAIT:
  - If btn_s = 1, return to HELD with rcnt = 0 and phase = 0, so repeat timing restarts at REPEAT_DELAY. No pulse.
  - Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE and assert release_pulse for one cycle.
  - Else cnt increments.
- Latency: T0 is the first rising edge at which btn_in is sampled active and it stays stable.
  - press_pulse, step and the rise of level occur at edge T0+DEBOUNCE_CYCLES+2.
  - Release is symmetric: release_pulse and the fall of level occur at T1+DEBOUNCE_CYCLES+2.
- Repeat timing: with press at edge E, repeats occur at E+REPEAT_DELAY, then every REPEAT_PERIOD after that.
- Counters never wrap. Each one is cleared on its terminal compare or on any state change.
- Button held through reset: treated as a new press after rst deasserts, with the full debounce latency.
- Pulses are never wider than one cycle. press_pulse and release_pulse are never high together.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, ACTIVE_LOW = 1.
1. Reset: rst high for 2 cycles with btn_in = 1 -> level, press_pulse, release_pulse and step all 0. Hold 20 cycles with no activity -> no pulse.
2. Clean press: btn_in goes 1 -> 0 first sampled at T0 and held -> press_pulse and step high only in the cycle after edge T0+6; level = 1 from T0+6.
3. Press bounce: btn_in toggles low 3 cycles / high 1 cycle, repeated 5 times, then returns high -> no pulses, level stays 0.
4. Release: from HELD, a 2-cycle high glitch -> no release_pulse, level stays 1. Then steady high first sampled at T1 -> release_pulse only at T1+6, level = 0 from T1+6.
5. Auto-repeat: REPEAT_EN = 1, press pulse at E, held 30 cycles -> step at E, E+10, E+13, E+16, E+19, E+22, E+25, E+28; press_pulse only at E.
6. Reset mid-operation:
   - rst asserted during PRESS_WAIT -> all outputs 0 at the next edge.
   - rst asserted in HELD with the button kept pressed, deasserted, first active sample at edge T0 -> press_pulse at T0+6, level = 1 from T0+6.
